ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Parametrised scan-code decoder between ps2_keyboard and the display/ascii logic.
//  Pops bytes from the ps2_keyboard FIFO, parses E0/F0 prefixes and emits one event per
//  make/break. Tracks up to MAX_HELD simultaneously held keys and suppresses typematic
//  repeats. Keeps a BCD count of new key presses for the seven-segment digits.
// PARAMETERS
//  COUNT_DIGITS  2  number of BCD digits in press_count; wraps at 10^COUNT_DIGITS-1 -> 0
//  MAX_HELD      4  held-key table entries (1..8); each entry is {ext, code[7:0]}
// PORTS
//  clk           in   1   system clock
//  rst           in   1   reset, asynchronous, active-low
//  ps2_data      in   8   FIFO head byte from ps2_keyboard
//  ps2_ready     in   1   FIFO non-empty
//  ps2_overflow  in   1   FIFO overflow flag
//  ps2_nextdata_n out 1   pop strobe to ps2_keyboard, active-low, one cycle
//  evt_valid     out  1   one-cycle pulse: key event on evt_* below
//  evt_code      out  8   scan code of event (prefixes stripped)
//  evt_ext       out  1   event carried E0 prefix
//  evt_break     out  1   1 = release, 0 = make
//  evt_repeat    out  1   make for a key already held (typematic)
//  err_pulse     out  1   one-cycle pulse: protocol error byte discarded
//  ovf_sticky    out  1   set when ps2_overflow seen high; cleared only by reset
//  last_code     out  8   code of most recent make (incl. repeats)
//  key_down      out  1   held_cnt != 0
//  held_cnt      out  4   number of valid held-table entries
//  held_full     out  1   held_cnt == MAX_HELD
//  press_count   out  4*COUNT_DIGITS  BCD count of new presses, digit 0 in [3:0]
// BEHAVIOUR
//  Reset (async, rst=0): every output 0 except ps2_nextdata_n=1; table cleared;
//   parser in IDLE. Reset mid-pop drops the byte and the partial prefix; no event issued.
//  Handshake: consumer is free and ps2_ready=1 in cycle N -> byte latched in N.
//   ps2_nextdata_n is a registered output, low in N+1 only. ps2_ready is ignored in
//   N+1 and N+2. The next byte is accepted no earlier than N+3.
//   All event/error pulses are registered and appear in N+1.
//  Parser states: IDLE, E0, F0, E0F0.
//   IDLE: E0->E0; F0->F0; 00/FF->err_pulse, stay; other->make event, ext=0.
//   E0:   F0->E0F0; E0/00/FF->err_pulse, IDLE; other->make, ext=1, IDLE.
//   F0:   E0/F0/00/FF->err_pulse, IDLE; other->break, ext=0, IDLE.
//   E0F0: E0/F0/00/FF->err_pulse, IDLE; other->break, ext=1, IDLE.
//  Make: match on {ext,code} in table -> evt_repeat=1, no count, no table change.
//   No match and not full -> insert in lowest free slot, press_count+1.
//   No match and full -> not stored, press_count+1.
//   last_code updates on every make.
//  Break: matching entry cleared; no match -> event still issued, table unchanged.
//  press_count: BCD ripple; each digit 0..9; all-9s + 1 -> all zeros, no flag.
//  held_cnt/held_full/key_down update in N+1, together with evt_valid.
//  ovf_sticky sets in the cycle after ps2_overflow=1; parsing continues.
// TESTING
//  1 1C, F0 1C -> make 1C (press_count=01, held_cnt=1), then break 1C
//    (held_cnt=0, key_down=0); nextdata_n low exactly 1 cycle per byte.
//  2 1C x3, F0 1C -> events 1: repeat=0; 2,3: repeat=1; press_count=01, last_code=1C.
//  3 E0 75, F0 75, E0 F0 75 -> make ext=1 / break ext=0 (no match) / break ext=1;
//    held_cnt 1,1,0.
//  4 MAX_HELD=4: makes 15 1D 24 2D 2C -> held_full after 4th; 5th issued, not stored;
//    press_count=05.
//  5 COUNT_DIGITS=2: 100 distinct make/break pairs -> press_count 99 then 00;
//    F0 E0 -> err_pulse, IDLE.
//  6 rst=0 asserted in cycle N+1 of a pop -> outputs zero immediately;
//    nextdata_n=1; no event after release.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// PS/2 FIFO pop interface between ps2_keyboard (master) and the key tracker (slave).
interface ps2_key_tracker_if;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;

    modport master (
        output ps2_data,
        output ps2_ready,
        output ps2_overflow,
        input  ps2_nextdata_n
    );

    modport slave (
        input  ps2_data,
        input  ps2_ready,
        input  ps2_overflow,
        output ps2_nextdata_n
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// Scan-code decoder: pops FIFO bytes, parses E0/F0 prefixes, tracks held keys,
// flags typematic repeats and keeps a BCD count of new presses.
module ps2_key_tracker #(
    parameter int COUNT_DIGITS = 2,
    parameter int MAX_HELD     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    ps2_key_tracker_if.slave          ps2,
    output logic                      evt_valid,
    output logic [7:0]                evt_code,
    output logic                      evt_ext,
    output logic                      evt_break,
    output logic                      evt_repeat,
    output logic                      err_pulse,
    output logic                      ovf_sticky,
    output logic [7:0]                last_code,
    output logic                      key_down,
    output logic [3:0]                held_cnt,
    output logic                      held_full,
    output logic [4*COUNT_DIGITS-1:0] press_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_E0   = 2'd1;
    localparam logic [1:0] ST_F0   = 2'd2;
    localparam logic [1:0] ST_E0F0 = 2'd3;

    logic [1:0] state_q, state_d;
    logic [1:0] cool_q;
    logic       accept;
    logic       nextdata_n_q;
    logic [7:0] byte_in;
    logic       is_prefix_e0, is_prefix_f0, is_bad;

    logic is_evt, evt_ext_d, evt_brk_d, err_d;

    logic [MAX_HELD-1:0]       valid_q, valid_d, match_v, ins_v;
    logic [MAX_HELD-1:0][8:0]  ent_q, ent_d;
    logic                      hit, free_found, inc;

    logic [4*COUNT_DIGITS-1:0] cnt_q, cnt_d;
    logic                      carry;
    logic [3:0]                held_cnt_c;

    logic       evt_valid_q, evt_ext_q, evt_break_q, evt_repeat_q, err_q, ovf_q;
    logic [7:0] evt_code_q, last_code_q;

    // A byte is taken only once the two-cycle pop cooldown has expired.
    assign accept       = ps2.ps2_ready && (cool_q == 2'd0);
    assign byte_in      = ps2.ps2_data;
    assign is_prefix_e0 = (byte_in == 8'hE0);
    assign is_prefix_f0 = (byte_in == 8'hF0);
    assign is_bad       = (byte_in == 8'h00) || (byte_in == 8'hFF);

    always_comb begin
        state_d   = state_q;
        is_evt    = 1'b0;
        evt_ext_d = 1'b0;
        evt_brk_d = 1'b0;
        err_d     = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_prefix_e0)      state_d = ST_E0;
                    else if (is_prefix_f0) state_d = ST_F0;
                    else if (is_bad)       err_d   = 1'b1;
                    else                   is_evt  = 1'b1;
                end
                ST_E0: begin
                    state_d = ST_IDLE;
                    if (is_prefix_f0) begin
                        state_d = ST_E0F0;
                    end else if (is_prefix_e0 || is_bad) begin
                        err_d = 1'b1;
                    end else begin
                        is_evt    = 1'b1;
                        evt_ext_d = 1'b1;
                    end
                end
                ST_F0: begin
                    state_d = ST_IDLE;
                    if (is_prefix_e0 || is_prefix_f0 || is_bad) begin
                        err_d = 1'b1;
                    end else begin
                        is_evt    = 1'b1;
                        evt_brk_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    if (is_prefix_e0 || is_prefix_f0 || is_bad) begin
                        err_d = 1'b1;
                    end else begin
                        is_evt    = 1'b1;
                        evt_ext_d = 1'b1;
                        evt_brk_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // Held table: at most one entry can match since duplicates are never inserted.
    always_comb begin
        hit        = 1'b0;
        free_found = 1'b0;
        inc        = 1'b0;
        match_v    = '0;
        ins_v      = '0;
        valid_d    = valid_q;
        ent_d      = ent_q;
        for (int unsigned i = 0; i < MAX_HELD; i++) begin
            if (valid_q[i] && (ent_q[i] == {evt_ext_d, byte_in})) begin
                match_v[i] = 1'b1;
                hit        = 1'b1;
            end
            if (!valid_q[i] && !free_found) begin
                ins_v[i]   = 1'b1;
                free_found = 1'b1;
            end
        end
        if (is_evt) begin
            if (evt_brk_d) begin
                valid_d = valid_q & ~match_v;
            end else if (!hit) begin
                inc = 1'b1;
                for (int unsigned i = 0; i < MAX_HELD; i++) begin
                    if (ins_v[i]) begin
                        valid_d[i] = 1'b1;
                        ent_d[i]   = {evt_ext_d, byte_in};
                    end
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        carry = inc;
        for (int unsigned d = 0; d < COUNT_DIGITS; d++) begin
            if (carry) begin
                if (cnt_q[4*d +: 4] == 4'd9) begin
                    cnt_d[4*d +: 4] = 4'd0;
                end else begin
                    cnt_d[4*d +: 4] = cnt_q[4*d +: 4] + 4'd1;
                    carry           = 1'b0;
                end
            end
        end
    end

    always_comb begin
        held_cnt_c = '0;
        for (int unsigned i = 0; i < MAX_HELD; i++) begin
            if (valid_q[i]) held_cnt_c = held_cnt_c + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cool_q       <= '0;
            nextdata_n_q <= 1'b1;
            valid_q      <= '0;
            ent_q        <= '0;
            cnt_q        <= '0;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= '0;
            evt_ext_q    <= 1'b0;
            evt_break_q  <= 1'b0;
            evt_repeat_q <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            last_code_q  <= '0;
        end else begin
            nextdata_n_q <= ~accept;
            if (accept)              cool_q <= 2'd2;
            else if (cool_q != 2'd0) cool_q <= cool_q - 2'd1;
            state_q     <= state_d;
            valid_q     <= valid_d;
            ent_q       <= ent_d;
            cnt_q       <= cnt_d;
            evt_valid_q <= is_evt;
            err_q       <= err_d;
            ovf_q       <= ovf_q | ps2.ps2_overflow;
            if (is_evt) begin
                evt_code_q   <= byte_in;
                evt_ext_q    <= evt_ext_d;
                evt_break_q  <= evt_brk_d;
                evt_repeat_q <= !evt_brk_d && hit;
                if (!evt_brk_d) last_code_q <= byte_in;
            end
        end
    end

    assign ps2.ps2_nextdata_n = nextdata_n_q;
    assign evt_valid          = evt_valid_q;
    assign evt_code           = evt_code_q;
    assign evt_ext            = evt_ext_q;
    assign evt_break          = evt_break_q;
    assign evt_repeat         = evt_repeat_q;
    assign err_pulse          = err_q;
    assign ovf_sticky         = ovf_q;
    assign last_code          = last_code_q;
    assign held_cnt           = held_cnt_c;
    assign key_down           = |valid_q;
    assign held_full          = (held_cnt_c == 4'(MAX_HELD));
    assign press_count        = cnt_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: expected events queued at stimulus time,
// popped and compared when evt_valid fires.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       evt_valid, evt_ext, evt_break, evt_repeat, err_pulse, ovf_sticky;
    logic       key_down, held_full;
    logic [7:0] evt_code, last_code;
    logic [3:0] held_cnt;
    logic [7:0] press_count;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [8:0] held_m[$];
    int         press_m = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         nd_low = 0;
    int         bytes_sent = 0;
    int         err_seen = 0;

    always #5 clk = ~clk;

    ps2_key_tracker_if ps2_bus ();

    ps2_key_tracker #(.COUNT_DIGITS(2), .MAX_HELD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2         (ps2_bus),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ext     (evt_ext),
        .evt_break   (evt_break),
        .evt_repeat  (evt_repeat),
        .err_pulse   (err_pulse),
        .ovf_sticky  (ovf_sticky),
        .last_code   (last_code),
        .key_down    (key_down),
        .held_cnt    (held_cnt),
        .held_full   (held_full),
        .press_count (press_count)
    );

    function automatic logic [7:0] bcd(input int n);
        logic [3:0] t, o;
        t = 4'((n / 10) % 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    // Scoreboard consumer; sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ps2_bus.ps2_nextdata_n === 1'b0) nd_low++;
            if (err_pulse === 1'b1) err_seen++;
            if (evt_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL evt_unexpected: got code=%h ext=%b brk=%b rep=%b, required no event",
                             evt_code, evt_ext, evt_break, evt_repeat);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({evt_code, evt_ext, evt_break, evt_repeat} !== mon_e) begin
                        n_bad++;
                        $display("FAIL evt_fields: got code=%h ext=%b brk=%b rep=%b, required code=%h ext=%b brk=%b rep=%b",
                                 evt_code, evt_ext, evt_break, evt_repeat,
                                 mon_e.code, mon_e.ext, mon_e.brk, mon_e.rep);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ps2_bus.ps2_data  = b;
        ps2_bus.ps2_ready = 1'b1;
        @(posedge clk);
        #1;
        ps2_bus.ps2_ready = 1'b0;
        bytes_sent++;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic key_make(input logic ext, input logic [7:0] code);
        exp_t e;
        logic rep = 1'b0;
        foreach (held_m[i]) if (held_m[i] == {ext, code}) rep = 1'b1;
        if (!rep) begin
            press_m = (press_m + 1) % 100;
            if (held_m.size() < 4) held_m.push_back({ext, code});
        end
        e.code = code; e.ext = ext; e.brk = 1'b0; e.rep = rep;
        exp_q.push_back(e);
        if (ext) send_byte(8'hE0);
        send_byte(code);
    endtask

    task automatic key_break(input logic ext, input logic [7:0] code);
        exp_t e;
        for (int i = 0; i < held_m.size(); i++) begin
            if (held_m[i] == {ext, code}) begin
                held_m.delete(i);
                break;
            end
        end
        e.code = code; e.ext = ext; e.brk = 1'b1; e.rep = 1'b0;
        exp_q.push_back(e);
        if (ext) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(code);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst                  = 1'b0;
        ps2_bus.ps2_data     = '0;
        ps2_bus.ps2_ready    = 1'b0;
        ps2_bus.ps2_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (ps2_bus.ps2_nextdata_n !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_nextdata: got %b, required 1", ps2_bus.ps2_nextdata_n);
        end
        n_cmp++;
        if ({evt_valid, evt_code, evt_ext, evt_break, evt_repeat, err_pulse, ovf_sticky} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_evt: got %b, required 0",
                     {evt_valid, evt_code, evt_ext, evt_break, evt_repeat, err_pulse, ovf_sticky});
        end
        n_cmp++;
        if ({last_code, key_down, held_cnt, held_full, press_count} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h, required 0",
                     {last_code, key_down, held_cnt, held_full, press_count});
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_make_break();
        int nd0 = nd_low;
        int b0  = bytes_sent;
        key_make(1'b0, 8'h1C);
        wait_drain();
        n_cmp++;
        if ({press_count, held_cnt, key_down, last_code} !== {8'h01, 4'd1, 1'b1, 8'h1C}) begin
            n_bad++;
            $display("FAIL make_state: got pc=%h held=%0d down=%b last=%h, required pc=01 held=1 down=1 last=1c",
                     press_count, held_cnt, key_down, last_code);
        end
        key_break(1'b0, 8'h1C);
        wait_drain();
        n_cmp++;
        if ({held_cnt, key_down} !== {4'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL break_state: got held=%0d down=%b, required held=0 down=0", held_cnt, key_down);
        end
        n_cmp++;
        if (nd_low - nd0 !== bytes_sent - b0) begin
            n_bad++;
            $display("FAIL nextdata_pulses: got %0d low cycles, required %0d", nd_low - nd0, bytes_sent - b0);
        end
    endtask

    task automatic test_repeat();
        repeat (3) key_make(1'b0, 8'h1C);
        wait_drain();
        n_cmp++;
        if ({press_count, held_cnt, last_code} !== {bcd(press_m), 4'd1, 8'h1C}) begin
            n_bad++;
            $display("FAIL repeat_state: got pc=%h held=%0d last=%h, required pc=%h held=1 last=1c",
                     press_count, held_cnt, last_code, bcd(press_m));
        end
        key_break(1'b0, 8'h1C);
        wait_drain();
    endtask

    task automatic test_ext();
        logic [3:0] want [3] = '{4'd1, 4'd1, 4'd0};
        for (int s = 0; s < 3; s++) begin
            case (s)
                0:       key_make(1'b1, 8'h75);
                1:       key_break(1'b0, 8'h75);
                default: key_break(1'b1, 8'h75);
            endcase
            wait_drain();
            n_cmp++;
            if (held_cnt !== want[s]) begin
                n_bad++;
                $display("FAIL ext_held step %0d: got %0d, required %0d", s, held_cnt, want[s]);
            end
        end
    endtask

    task automatic test_full();
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        for (int i = 0; i < 5; i++) begin
            key_make(1'b0, codes[i]);
            wait_drain();
            n_cmp++;
            if ({held_full, held_cnt} !== {(i >= 3), 4'(held_m.size())}) begin
                n_bad++;
                $display("FAIL full_step %0d: got full=%b held=%0d, required full=%b held=%0d",
                         i, held_full, held_cnt, (i >= 3), held_m.size());
            end
        end
        n_cmp++;
        if (press_count !== bcd(press_m)) begin
            n_bad++;
            $display("FAIL full_press: got %h, required %h", press_count, bcd(press_m));
        end
        for (int i = 0; i < 5; i++) key_break(1'b0, codes[i]);
        wait_drain();
        n_cmp++;
        if (held_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL full_clear: got %0d, required 0", held_cnt);
        end
    endtask

    task automatic test_wrap_and_errors();
        int e0;
        bit saw99 = 1'b0;
        bit saw00 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            key_make(1'b0, 8'(i + 1));
            key_break(1'b0, 8'(i + 1));
            if (press_m == 99) saw99 = 1'b1;
            if (press_m == 0 && saw99) saw00 = 1'b1;
            n_cmp++;
            if (press_count !== bcd(press_m)) begin
                n_bad++;
                $display("FAIL wrap_press pair %0d: got %h, required %h", i, press_count, bcd(press_m));
            end
        end
        n_cmp++;
        if (!(saw99 && saw00)) begin
            n_bad++;
            $display("FAIL wrap_coverage: got saw99=%b saw00=%b, required both 1", saw99, saw00);
        end
        wait_drain();
        e0 = err_seen;
        send_byte(8'hF0);
        send_byte(8'hE0);
        n_cmp++;
        if (err_seen - e0 !== 1) begin
            n_bad++;
            $display("FAIL err_f0e0: got %0d pulses, required 1", err_seen - e0);
        end
        send_byte(8'h00);
        send_byte(8'hE0);
        send_byte(8'hFF);
        n_cmp++;
        if (err_seen - e0 !== 3) begin
            n_bad++;
            $display("FAIL err_total: got %0d pulses, required 3", err_seen - e0);
        end
        key_make(1'b0, 8'h1C);
        key_break(1'b0, 8'h1C);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   nd0 = nd_low;
        held_m.push_back({1'b0, 8'h2B});
        press_m = (press_m + 1) % 100;
        for (int i = 0; i < 3; i++) begin
            e.code = 8'h2B; e.ext = 1'b0; e.brk = 1'b0; e.rep = (i != 0);
            exp_q.push_back(e);
        end
        @(negedge clk);
        ps2_bus.ps2_data  = 8'h2B;
        ps2_bus.ps2_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        ps2_bus.ps2_ready = 1'b0;
        bytes_sent += 3;
        repeat (3) @(posedge clk);
        wait_drain();
        n_cmp++;
        if (nd_low - nd0 !== 3) begin
            n_bad++;
            $display("FAIL b2b_pops: got %0d, required 3", nd_low - nd0);
        end
        n_cmp++;
        if ({held_cnt, press_count} !== {4'd1, bcd(press_m)}) begin
            n_bad++;
            $display("FAIL b2b_state: got held=%0d pc=%h, required held=1 pc=%h",
                     held_cnt, press_count, bcd(press_m));
        end
        key_break(1'b0, 8'h2B);
        wait_drain();
    endtask

    task automatic test_overflow();
        n_cmp++;
        if (ovf_sticky !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_pre: got %b, required 0", ovf_sticky);
        end
        @(negedge clk);
        ps2_bus.ps2_overflow = 1'b1;
        @(negedge clk);
        ps2_bus.ps2_overflow = 1'b0;
        key_make(1'b0, 8'h33);
        key_break(1'b0, 8'h33);
        wait_drain();
        n_cmp++;
        if (ovf_sticky !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_sticky: got %b, required 1", ovf_sticky);
        end
    endtask

    task automatic test_reset_mid_pop();
        key_make(1'b0, 8'h4A);
        wait_drain();
        @(negedge clk);
        ps2_bus.ps2_data  = 8'hE0;
        ps2_bus.ps2_ready = 1'b1;
        @(posedge clk);
        #1;
        ps2_bus.ps2_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        held_m.delete();
        press_m = 0;
        n_cmp++;
        if (ps2_bus.ps2_nextdata_n !== 1'b1) begin
            n_bad++;
            $display("FAIL midpop_nextdata: got %b, required 1", ps2_bus.ps2_nextdata_n);
        end
        n_cmp++;
        if ({evt_valid, err_pulse, ovf_sticky, key_down, held_cnt, press_count, last_code} !== 24'd0) begin
            n_bad++;
            $display("FAIL midpop_outputs: got %h, required 0",
                     {evt_valid, err_pulse, ovf_sticky, key_down, held_cnt, press_count, last_code});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        key_make(1'b0, 8'h1C);
        key_make(1'b0, 8'h4A);
        wait_drain();
        n_cmp++;
        if ({held_cnt, press_count, last_code} !== {4'd2, 8'h02, 8'h4A}) begin
            n_bad++;
            $display("FAIL midpop_after: got held=%0d pc=%h last=%h, required held=2 pc=02 last=4a",
                     held_cnt, press_count, last_code);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_make_break();
        test_repeat();
        test_ext();
        test_full();
        test_wrap_and_errors();
        test_back_to_back();
        test_overflow();
        test_reset_mid_pop();
        repeat (10) @(posedge clk);
        wait_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
